// File: rtl/elevator_pkg.sv
// Shared types and helpers for the N-floor elevator controller.
// Pending bitmaps are passed zero-extended to MAX_FLOORS bits.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        DOOR  = 2'd2,
        ESTOP = 2'd3
    } state_t;

    localparam int MAX_FLOORS = 16;

    function automatic logic has_pending_above(
        input logic [MAX_FLOORS-1:0] pend,
        input int                    floor
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++)
            if (i > floor && pend[i])
                r = 1'b1;
        return r;
    endfunction

    function automatic logic has_pending_below(
        input logic [MAX_FLOORS-1:0] pend,
        input int                    floor
    );
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++)
            if (i < floor && pend[i])
                r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/elevator_ctrl_n_tick_gen.sv
// Movement tick divider: one-clk pulse every TICK_DIV clocks.
// clr holds the count at zero so the next tick is a full period away.
module tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor SCAN elevator controller with door timer and emergency stop.
// Calls latch into a pending bitmap; the car serves calls ahead first.
module elevator_ctrl_n
    import elevator_pkg::*;
#(
    parameter int   NUM_FLOORS = 8,
    parameter int   TICK_DIV   = 10_000_000,
    parameter int   DOOR_TICKS = 3,
    localparam int  FW         = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [FW-1:0]         req_floor,
    input  logic                  estop,
    output logic [FW-1:0]         cur_floor,
    output logic                  moving,
    output logic                  dir_up,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  req_err
);

    localparam int DW = $clog2(DOOR_TICKS + 1);

    state_t                  state;
    logic [DW-1:0]           door_cnt;
    logic                    tick;
    logic [MAX_FLOORS-1:0]   pend_w;
    logic [FW-1:0]           nxt_floor;
    logic [NUM_FLOORS-1:0]   set_mask;
    logic [NUM_FLOORS-1:0]   cur_oh;
    logic [NUM_FLOORS-1:0]   nxt_oh;
    logic                    in_range;
    logic                    restart;
    logic                    above;
    logic                    below;
    logic                    go_move;
    logic                    go_dir;
    logic                    cur_hit;
    logic                    nxt_hit;
    logic                    nxt_ahead;
    logic                    blocked;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (estop),
        .tick (tick)
    );

    always_comb begin
        in_range = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (req_floor == FW'(i))
                in_range = 1'b1;
    end

    assign pend_w    = MAX_FLOORS'(pending);
    assign restart   = (state == DOOR) && req_valid
                     && (req_floor == cur_floor);
    assign set_mask  = (req_valid && in_range && !restart)
                     ? (NUM_FLOORS'(1) << req_floor) : '0;
    assign cur_oh    = NUM_FLOORS'(1) << cur_floor;
    assign nxt_oh    = NUM_FLOORS'(1) << nxt_floor;

    assign above     = has_pending_above(pend_w, int'(cur_floor));
    assign below     = has_pending_below(pend_w, int'(cur_floor));
    assign go_move   = above | below;
    // Keep heading while calls lie ahead, otherwise reverse.
    assign go_dir    = dir_up ? above : ~below;
    assign cur_hit   = pend_w[4'(cur_floor)];

    assign blocked   = dir_up ? (cur_floor == FW'(NUM_FLOORS - 1))
                              : (cur_floor == '0);
    assign nxt_floor = dir_up ? cur_floor + FW'(1)
                              : cur_floor - FW'(1);
    assign nxt_hit   = pend_w[4'(nxt_floor)];
    assign nxt_ahead = dir_up
                     ? has_pending_above(pend_w, int'(nxt_floor))
                     : has_pending_below(pend_w, int'(nxt_floor));

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_floor <= '0;
            dir_up    <= 1'b1;
            pending   <= '0;
            door_cnt  <= '0;
            req_err   <= 1'b0;
        end else begin
            req_err <= req_valid && !in_range;
            pending <= pending | set_mask;
            if (estop) begin
                state <= ESTOP;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tick) begin
                            if (cur_hit) begin
                                state   <= DOOR;
                                pending <= (pending & ~cur_oh) | set_mask;
                            end else if (go_move) begin
                                state  <= MOVE;
                                dir_up <= go_dir;
                            end
                        end
                    end
                    MOVE: begin
                        if (tick) begin
                            if (blocked) begin
                                state <= IDLE;
                            end else begin
                                cur_floor <= nxt_floor;
                                if (nxt_hit) begin
                                    state   <= DOOR;
                                    pending <= (pending & ~nxt_oh) | set_mask;
                                end else if (!nxt_ahead) begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    DOOR: begin
                        if (restart) begin
                            door_cnt <= '0;
                        end else if (tick) begin
                            if (door_cnt == DW'(DOOR_TICKS - 1)) begin
                                door_cnt <= '0;
                                if (go_move) begin
                                    state  <= MOVE;
                                    dir_up <= go_dir;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                door_cnt <= door_cnt + DW'(1);
                            end
                        end
                    end
                    ESTOP: begin
                        state    <= IDLE;
                        door_cnt <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Directed scenarios plus randomized traffic for elevator_ctrl_n,
// checked every cycle against a floor/call-level reference model.
module tb_elevator_ctrl_n;

    localparam int NF = 8;
    localparam int TD = 4;
    localparam int DT = 2;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       estop;
    logic [2:0] cur_floor;
    logic       moving;
    logic       dir_up;
    logic       door_open;
    logic [7:0] pending;
    logic       req_err;

    logic       r2_valid;
    logic [2:0] r2_floor;
    logic [2:0] f2;
    logic       mv2;
    logic       up2;
    logic       dr2;
    logic [5:0] pend2;
    logic       err2;
    logic       estop2;

    int errors;
    int checks;
    int cyc_n;

    int m_floor;
    int m_mode;
    bit m_up;
    int m_tc;
    int m_dc;
    bit m_p[NF];
    bit m_err;

    elevator_ctrl_n #(
        .NUM_FLOORS(NF),
        .TICK_DIV  (TD),
        .DOOR_TICKS(DT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_floor(req_floor),
        .estop    (estop),
        .cur_floor(cur_floor),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open),
        .pending  (pending),
        .req_err  (req_err)
    );

    elevator_ctrl_n #(
        .NUM_FLOORS(6),
        .TICK_DIV  (TD),
        .DOOR_TICKS(DT)
    ) dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(r2_valid),
        .req_floor(r2_floor),
        .estop    (estop2),
        .cur_floor(f2),
        .moving   (mv2),
        .dir_up   (up2),
        .door_open(dr2),
        .pending  (pend2),
        .req_err  (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc_n, got, exp);
        end
    endtask

    function automatic bit any_above(int f);
        for (int i = f + 1; i < NF; i++)
            if (m_p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit any_below(int f);
        for (int i = 0; i < f; i++)
            if (m_p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0;
        m_mode  = 0;
        m_up    = 1'b1;
        m_tc    = 0;
        m_dc    = 0;
        m_err   = 1'b0;
        for (int i = 0; i < NF; i++) m_p[i] = 1'b0;
    endtask

    // SCAN choice: prefer calls in the current heading, else turn round.
    task automatic decide();
        bit a;
        bit b;
        a = any_above(m_floor);
        b = any_below(m_floor);
        if ((m_up && a) || (!m_up && b)) begin
            m_mode = 1;
        end else if (a) begin
            m_mode = 1;
            m_up   = 1'b1;
        end else if (b) begin
            m_mode = 1;
            m_up   = 1'b0;
        end else begin
            m_mode = 0;
        end
    endtask

    // modes: 0 idle, 1 moving, 2 door open, 3 stopped
    task automatic model_step();
        bit tick;
        bit restart;
        bit ahead;
        int rf;
        int clr;
        int nf;
        tick    = (m_tc == TD - 1);
        rf      = int'(req_floor);
        restart = (m_mode == 2) && req_valid && (rf == m_floor);
        m_err   = req_valid && (rf >= NF);
        clr     = -1;
        if (estop) begin
            m_mode = 3;
        end else if (m_mode == 3) begin
            m_mode = 0;
            m_dc   = 0;
        end else if (m_mode == 0) begin
            if (tick) begin
                if (m_p[m_floor]) begin
                    m_mode = 2;
                    clr    = m_floor;
                end else begin
                    decide();
                end
            end
        end else if (m_mode == 1) begin
            if (tick) begin
                nf      = m_up ? m_floor + 1 : m_floor - 1;
                ahead   = m_up ? any_above(nf) : any_below(nf);
                m_floor = nf;
                if (m_p[nf]) begin
                    m_mode = 2;
                    clr    = nf;
                end else if (!ahead) begin
                    m_mode = 0;
                end
            end
        end else begin
            if (restart) begin
                m_dc = 0;
            end else if (tick) begin
                if (m_dc + 1 == DT) begin
                    m_dc = 0;
                    decide();
                end else begin
                    m_dc++;
                end
            end
        end
        if (clr >= 0) m_p[clr] = 1'b0;
        if (req_valid && rf < NF && !restart) m_p[rf] = 1'b1;
        m_tc = (estop || tick) ? 0 : m_tc + 1;
    endtask

    task automatic compare();
        logic [7:0] mp;
        for (int i = 0; i < NF; i++) mp[i] = m_p[i];
        chk("cur_floor", 32'(cur_floor), 32'(m_floor));
        chk("moving", 32'(moving), 32'(m_mode == 1));
        chk("door_open", 32'(door_open), 32'(m_mode == 2));
        chk("dir_up", 32'(dir_up), 32'(m_up));
        chk("pending", 32'(pending), 32'(mp));
        chk("req_err", 32'(req_err), 32'(m_err));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        compare();
        req_valid = 1'b0;
        r2_valid  = 1'b0;
    endtask

    task automatic run_to(input int n);
        while (cyc_n < n) step();
    endtask

    task automatic req(input int f);
        req_valid = 1'b1;
        req_floor = 3'(f);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc_n = 0;
    endtask

    initial begin
        int estop_left;
        errors    = 0;
        checks    = 0;
        cyc_n     = 0;
        req_valid = 1'b0;
        req_floor = '0;
        estop     = 1'b0;
        r2_valid  = 1'b0;
        r2_floor  = '0;
        estop2    = 1'b0;
        do_reset();

        // six-floor instance: out-of-range calls rejected
        r2_valid = 1'b1;
        r2_floor = 3'd7;
        step();
        chk("err6_hi", 32'(err2), 32'd1);
        chk("pend6_keep", 32'(pend2), 32'h0);
        step();
        chk("err6_pulse", 32'(err2), 32'd0);
        r2_valid = 1'b1;
        r2_floor = 3'd5;
        step();
        chk("pend6_set", 32'(pend2), 32'h20);
        chk("err6_ok", 32'(err2), 32'd0);
        r2_valid = 1'b1;
        r2_floor = 3'd6;
        step();
        chk("err6_edge", 32'(err2), 32'd1);
        chk("pend6_edge", 32'(pend2), 32'h20);

        run_to(20);
        chk("idle_floor", 32'(cur_floor), 32'd0);
        chk("idle_moving", 32'(moving), 32'd0);
        chk("idle_door", 32'(door_open), 32'd0);
        chk("idle_pend", 32'(pending), 32'd0);
        chk("idle_dir", 32'(dir_up), 32'd1);

        req(3);
        chk("p3_set", 32'(pending), 32'h08);
        run_to(24);
        chk("t1_moving", 32'(moving), 32'd1);
        run_to(28);
        chk("t2_floor", 32'(cur_floor), 32'd1);
        run_to(32);
        chk("t3_floor", 32'(cur_floor), 32'd2);
        run_to(36);
        chk("t4_floor", 32'(cur_floor), 32'd3);
        chk("t4_door", 32'(door_open), 32'd1);
        chk("t4_pend", 32'(pending), 32'd0);
        run_to(40);
        chk("t5_door", 32'(door_open), 32'd1);
        run_to(44);
        chk("t6_door", 32'(door_open), 32'd0);
        chk("t6_moving", 32'(moving), 32'd0);

        req(1);
        run_to(48);
        chk("scan_dn_mv", 32'(moving), 32'd1);
        chk("scan_dn_dir", 32'(dir_up), 32'd0);
        req(5);
        run_to(56);
        chk("scan_f1", 32'(cur_floor), 32'd1);
        chk("scan_f1_door", 32'(door_open), 32'd1);
        run_to(64);
        chk("scan_rev_mv", 32'(moving), 32'd1);
        chk("scan_rev_dir", 32'(dir_up), 32'd1);
        run_to(80);
        chk("scan_f5", 32'(cur_floor), 32'd5);
        chk("scan_f5_door", 32'(door_open), 32'd1);

        do_reset();
        req(3);
        run_to(13);
        chk("es_pre_floor", 32'(cur_floor), 32'd2);
        estop = 1'b1;
        step();
        chk("es_moving", 32'(moving), 32'd0);
        chk("es_floor", 32'(cur_floor), 32'd2);
        chk("es_pend", 32'(pending), 32'h08);
        run_to(17);
        estop = 1'b0;
        step();
        chk("es_rel_idle", 32'(moving), 32'd0);
        run_to(21);
        chk("es_resume", 32'(moving), 32'd1);
        run_to(25);
        chk("es_f3", 32'(cur_floor), 32'd3);
        chk("es_f3_door", 32'(door_open), 32'd1);

        run_to(29);
        req(3);
        chk("rq_pend", 32'(pending), 32'd0);
        run_to(33);
        chk("rq_door_held", 32'(door_open), 32'd1);
        run_to(37);
        chk("rq_door_shut", 32'(door_open), 32'd0);

        req(6);
        run_to(46);
        chk("rst_pre_floor", 32'(cur_floor), 32'd4);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_floor", 32'(cur_floor), 32'd0);
        chk("arst_moving", 32'(moving), 32'd0);
        chk("arst_pend", 32'(pending), 32'd0);
        chk("arst_dir", 32'(dir_up), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_n = 0;

        estop_left = 0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                req_valid = 1'b1;
                req_floor = 3'($urandom_range(0, NF - 1));
            end
            if (estop_left > 0) begin
                estop_left--;
                estop = (estop_left > 0);
            end else if ($urandom_range(0, 399) == 0) begin
                estop_left = $urandom_range(2, 12);
                estop = 1'b1;
            end
            if ($urandom_range(0, 1499) == 0) begin
                estop      = 1'b0;
                estop_left = 0;
                req_valid  = 1'b0;
                do_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
